// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - steps a 3-input device through vectors 0..7 and records its truth table
module truth_table_sweeper #(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       f_in,
  input  logic [7:0] expected,
  output logic       v_out,
  output logic       i_out,
  output logic       h_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] truth_table,
  output logic       match
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

  state_t     state, state_nxt;
  logic [2:0] idx;
  logic [3:0] cnt;
  logic [7:0] capture;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start && !abort) state_nxt = S_SETTLE;
      S_SETTLE: begin
        if (abort)                state_nxt = S_IDLE;
        else if (cnt == CNT_LAST) state_nxt = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (abort)             state_nxt = S_IDLE;
        else if (idx == 3'd7)  state_nxt = S_DONE;
        else                   state_nxt = S_SETTLE;
      end
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Stimulus is driven straight from idx so it is stable through settle and sample.
  always_comb begin
    busy = (state != S_IDLE);
    done = (state == S_DONE);
    {v_out, i_out, h_out} = 3'b000;
    if (state == S_SETTLE || state == S_SAMPLE) {v_out, i_out, h_out} = idx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx         <= 3'd0;
      cnt         <= 4'd0;
      capture     <= 8'h00;
      truth_table <= 8'h00;
      match       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            idx     <= 3'd0;
            cnt     <= 4'd0;
            capture <= 8'h00;
          end
        end
        S_SETTLE: if (!abort) cnt <= cnt + 4'd1;
        S_SAMPLE: begin
          if (!abort) begin
            capture[idx] <= f_in;
            if (idx != 3'd7) begin
              idx <= idx + 3'd1;
              cnt <= 4'd0;
            end
          end
        end
        S_DONE: begin
          truth_table <= capture;
          match       <= (capture == expected);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - scoreboard bench for truth_table_sweeper with SETTLE=2 and SETTLE=1
module tb_truth_table_sweeper;

  logic       clk = 1'b0;
  logic       reset, start, abort;
  logic [7:0] expected, dev_tt;

  logic       v2, i2, h2, busy2, done2, match2, f2;
  logic [7:0] tt2;
  logic       v1, i1, h1, busy1, done1, match1, f1;
  logic [7:0] tt1;

  int         sel;
  logic [2:0] o_vec;
  logic       o_busy, o_done, o_match;
  logic [7:0] o_tt;
  int         o_dcnt;

  int         total = 0;
  int         bad = 0;
  int         dcnt1 = 0;
  int         dcnt2 = 0;
  logic [8:0] sbq[$];
  logic [7:0] last_tt;
  logic       last_match;

  always #5 clk = ~clk;

  assign f2 = dev_tt[{v2, i2, h2}];
  assign f1 = dev_tt[{v1, i1, h1}];

  truth_table_sweeper #(.SETTLE(2)) dut2 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .f_in(f2),
    .expected(expected), .v_out(v2), .i_out(i2), .h_out(h2), .busy(busy2),
    .done(done2), .truth_table(tt2), .match(match2)
  );

  truth_table_sweeper #(.SETTLE(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .f_in(f1),
    .expected(expected), .v_out(v1), .i_out(i1), .h_out(h1), .busy(busy1),
    .done(done1), .truth_table(tt1), .match(match1)
  );

  always_comb begin
    if (sel == 1) begin
      o_vec = {v1, i1, h1}; o_busy = busy1; o_done = done1; o_tt = tt1; o_match = match1; o_dcnt = dcnt1;
    end else begin
      o_vec = {v2, i2, h2}; o_busy = busy2; o_done = done2; o_tt = tt2; o_match = match2; o_dcnt = dcnt2;
    end
  end

  always @(negedge clk) begin
    if (done1) dcnt1++;
    if (done2) dcnt2++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic sweep(input int s, input logic [7:0] dev, input logic [7:0] exp_tt, input bit poke);
    int         hold;
    int         n_done;
    logic [8:0] ent;
    hold     = s + 1;
    sel      = s;
    dev_tt   = dev;
    expected = exp_tt;
    sbq.push_back({dev == exp_tt, dev});
    @(negedge clk);
    n_done = o_dcnt;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k < 8 * hold; k++) begin
      @(negedge clk);
      check("vec", o_vec, k / hold);
      check("busy", o_busy, 1);
      check("done_early", o_done, 0);
      start = poke && (k == 10);
    end
    @(negedge clk);
    check("done_pulse", o_done, 1);
    check("vec_done", o_vec, 0);
    start = poke;
    abort = poke;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("done_one_cycle", o_done, 0);
    check("idle_after", o_busy, 0);
    if (sbq.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      ent = sbq.pop_front();
      check("table", o_tt, ent[7:0]);
      check("match", o_match, ent[8]);
      last_tt    = ent[7:0];
      last_match = ent[8];
    end
    repeat (12) @(negedge clk);
    check("no_restart", o_busy, 0);
    check("done_count", o_dcnt - n_done, 1);
  endtask

  task automatic abort_test();
    int n_done;
    sel      = 2;
    dev_tt   = 8'h96;
    expected = 8'h96;
    @(negedge clk);
    n_done = dcnt2;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    check("abort_vec3", o_vec, 3);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check("abort_busy", o_busy, 0);
    check("abort_vec", o_vec, 0);
    repeat (30) @(negedge clk);
    check("abort_no_done", dcnt2 - n_done, 0);
    check("abort_table", o_tt, last_tt);
    check("abort_match", o_match, last_match);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    abort = 1'b0;
    check("abort_wins", o_busy, 0);
  endtask

  task automatic reset_test();
    sel      = 2;
    dev_tt   = 8'hFF;
    expected = 8'hFF;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (16) @(negedge clk);
    check("rst_vec5", o_vec, 5);
    #2 reset = 1'b0;
    #1;
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_vec", o_vec, 0);
    check("rst_table", o_tt, 8'h00);
    check("rst_match", o_match, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_idle", o_busy, 0);
  endtask

  initial begin
    logic [7:0] r;
    reset    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    expected = 8'h00;
    dev_tt   = 8'h00;
    sel      = 2;
    #1;
    check("init_busy", o_busy, 0);
    check("init_done", o_done, 0);
    check("init_vec", o_vec, 0);
    check("init_table", o_tt, 8'h00);
    check("init_match", o_match, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    sweep(2, 8'h96, 8'h96, 1'b0);
    sweep(2, 8'hFF, 8'h96, 1'b0);
    abort_test();
    sweep(2, 8'h96, 8'h96, 1'b1);
    r = 8'($urandom);
    sweep(2, r, r, 1'b0);
    r = 8'($urandom);
    sweep(2, r, ~r, 1'b0);
    reset_test();
    sweep(2, 8'h5A, 8'h5A, 1'b0);
    sweep(1, 8'h96, 8'h96, 1'b0);
    sweep(1, 8'h3C, 8'h96, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
